// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus owner arbiter: state encoding, width helper
// and default configuration constants.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int DEF_TURN_CYC = 1;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/bus_owner_arbiter_rr_pick.sv
// Round-robin winner search: scans from last+1 upward, wrapping from NREQ-1
// back to 0, and reports the first requester found.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int OWNW = clog2_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OWNW-1:0] last,
  output logic            valid,
  output logic [OWNW-1:0] idx
);

  int              cand;
  logic [OWNW-1:0] cand_idx;

  // Walk the candidates farthest-first so the nearest set bit is written last and wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional write; a missing default on some path infers a latch.
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand     = (int'(last) + k) % NREQ;
      cand_idx = OWNW'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus. Grants are one-hot or
// zero and feed each driver's data_en; a turnaround of TURN_CYC all-off cycles
// separates consecutive owners so no two drivers ever overlap.
// Optional build macro BUS_OWNER_ARBITER_LOCK_EN adds a `lock` input that lets
// the current owner suppress hold-limit preemption while it keeps requesting.
module bus_owner_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NREQ     = DEF_NREQ,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  parameter  int TURN_CYC = DEF_TURN_CYC,
  localparam int OWNW     = clog2_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
`ifdef BUS_OWNER_ARBITER_LOCK_EN
  input  logic            lock,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [OWNW-1:0] owner,
  output logic            bus_idle
);

  localparam int HOLDW = clog2_w(MAX_HOLD);
  localparam int TURNW = clog2_w(TURN_CYC);
  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);
  localparam logic [TURNW-1:0] TURN_LAST = TURNW'(TURN_CYC - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0  = NREQ'(1);

  state_t          state;
  logic [HOLDW-1:0] hold_cnt;
  logic [TURNW-1:0] turn_cnt;
  logic [OWNW-1:0]  last;

  logic            pick_valid;
  logic [OWNW-1:0] pick_idx;
  logic            locked;
  logic            others_waiting;
  logic            release_own;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef BUS_OWNER_ARBITER_LOCK_EN
  assign locked = lock & req[owner];
`else
  assign locked = 1'b0;
`endif

  // Owner gives up the bus when it stops requesting, or when its hold budget is
  // spent and somebody else is waiting (unless it holds the lock).
  assign others_waiting = |(req & ~gnt);
  assign release_own    = !req[owner] || (!locked && (hold_cnt == HOLD_LAST) && others_waiting);

  // Single-process FSM with registered grant, owner and idle outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      bus_idle <= 1'b1;
      hold_cnt <= '0;
      turn_cnt <= '0;
      last     <= OWNW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt      <= ONE_HOT0 << pick_idx;
            owner    <= pick_idx;
            last     <= pick_idx;
            hold_cnt <= '0;
            bus_idle <= 1'b0;
            state    <= ST_OWN;
          end
        end

        ST_OWN: begin
          if (release_own) begin
            gnt      <= '0;
            owner    <= '0;
            turn_cnt <= '0;
            bus_idle <= 1'b0;
            state    <= ST_TURN;
          end else if (locked) begin
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_TURN: begin
          if (turn_cnt == TURN_LAST) begin
            if (pick_valid) begin
              gnt      <= ONE_HOT0 << pick_idx;
              owner    <= pick_idx;
              last     <= pick_idx;
              hold_cnt <= '0;
              bus_idle <= 1'b0;
              state    <= ST_OWN;
            end else begin
              bus_idle <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end

        default: begin
          gnt      <= '0;
          owner    <= '0;
          bus_idle <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Bench for bus_owner_arbiter: directed steps from the test plan followed by a
// random-request phase, all compared cycle by cycle with a behavioural model.
module tb_bus_owner_arbiter;

  localparam int N     = 4;
  localparam int MAXH  = 4;
  localparam int TURN  = 1;
  localparam int BOUND = (N - 1) * (MAXH + TURN) + TURN;
`ifdef BUS_OWNER_ARBITER_LOCK_EN
  localparam bit HAS_LOCK = 1'b1;
`else
  localparam bit HAS_LOCK = 1'b0;
`endif

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic [N-1:0] req  = '0;
  logic         lock = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         bus_idle;

  always #5 clk = ~clk;

  bus_owner_arbiter #(.NREQ(N), .MAX_HOLD(MAXH), .TURN_CYC(TURN)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
`ifdef BUS_OWNER_ARBITER_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .owner    (owner),
    .bus_idle (bus_idle)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: who owns the bus, for how many cycles, and how many
  // dead cycles have elapsed since the last owner let go.
  int m_owner = -1;
  int m_run   = 0;
  int m_dead  = 0;
  int m_last  = N - 1;

  function automatic int rr_winner(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_step();
    int  w;
    bit  lk;
    bit  others;
    if (rst) begin
      m_owner = -1; m_run = 0; m_dead = 0; m_last = N - 1;
    end else if (m_owner >= 0) begin
      lk     = HAS_LOCK && lock && req[m_owner];
      others = (req & ~(N'(1) << m_owner)) != 0;
      if (!req[m_owner] || (!lk && m_run >= MAXH && others)) begin
        m_owner = -1;
        m_dead  = 1;
      end else begin
        m_run = lk ? 1 : ((m_run + 1 > MAXH) ? MAXH : m_run + 1);
      end
    end else if (m_dead > 0 && m_dead < TURN) begin
      m_dead++;
    end else begin
      w = rr_winner(req, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_run = 1;
      end
      m_dead = 0;
    end
  endfunction

  // Invariant bookkeeping.
  logic [N-1:0] prev_gnt = '0;
  bit           seen_grant = 1'b0;
  int           zero_run = 0;
  bit           fair_en = 1'b0;
  int           waitc [N];

  task automatic tick();
    if (fair_en) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) waitc[i]++;
        else waitc[i] = 0;
        check($sformatf("fair_wait_%0d", i), 32'(waitc[i] <= BOUND), 32'd1);
      end
    end
    @(posedge clk);
    model_step();
    #1;
    check("model_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("model_owner", 32'(owner), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("model_idle", 32'(bus_idle), 32'(m_owner < 0 && m_dead == 0));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (rst) begin
      seen_grant = 1'b0;
      zero_run   = 0;
    end else if (gnt != '0) begin
      if (prev_gnt == '0 && seen_grant) check("turn_gap", 32'(zero_run >= TURN), 32'd1);
      if (prev_gnt != '0) check("no_switch", 32'(gnt), 32'(prev_gnt));
      seen_grant = 1'b1;
      zero_run   = 0;
    end else begin
      zero_run++;
    end
    prev_gnt = gnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) waitc[i] = 0;

    // Reset held two cycles with all requests high, then first grant to 0.
    rst = 1'b1; req = 4'b1111;
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_idle", 32'(bus_idle), 32'd1);
    tick();
    check("rst2_gnt", 32'(gnt), 32'd0);
    rst = 1'b0;
    tick();
    check("first_gnt", 32'(gnt), 32'b0001);

    // All requesting: owners rotate 0,1,2,3,0 with four owned cycles and one dead.
    for (int k = 1; k < 25; k++) begin
      tick();
      check($sformatf("rotate_%0d", k), 32'(gnt),
            (k % 5 < 4) ? (32'd1 << ((k / 5) % 4)) : 32'd0);
    end

    // Single requester 2: grant, drop, turnaround, idle.
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; req = 4'b0100;
    tick();
    check("r2_gnt", 32'(gnt), 32'b0100);
    check("r2_owner", 32'(owner), 32'd2);
    check("r2_idle", 32'(bus_idle), 32'd0);
    tick();
    tick();
    req = '0;
    tick();
    check("r2_rel_gnt", 32'(gnt), 32'd0);
    check("r2_turn_idle", 32'(bus_idle), 32'd0);
    tick();
    check("r2_back_idle", 32'(bus_idle), 32'd1);

    // Lone requester keeps the bus; a newcomer forces release after the hold limit.
    req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("solo_%0d", k), 32'(gnt), 32'b0001);
    end
    req = 4'b1001;
    tick();
    check("preempt_dead", 32'(gnt), 32'd0);
    tick();
    check("preempt_gnt", 32'(gnt), 32'b1000);
    check("preempt_owner", 32'(owner), 32'd3);

    // Reset during ownership abandons it; round robin restarts from requester 0.
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; req = 4'b0010;
    tick();
    check("own1_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1;
    tick();
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_owner", 32'(owner), 32'd0);
    check("midrst_idle", 32'(bus_idle), 32'd1);
    rst = 1'b0; req = 4'b1010;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    check("post_rst_owner", 32'(owner), 32'd1);

    // Random request traffic.
    fair_en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      tick();
    end
    fair_en = 1'b0;

`ifdef BUS_OWNER_ARBITER_LOCK_EN
    // Locked owner 2 outlasts the hold limit despite full contention.
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; req = 4'b0100;
    tick();
    check("lock_gnt", 32'(gnt), 32'b0100);
    lock = 1'b1; req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("locked_%0d", k), 32'(gnt), 32'b0100);
    end
    lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("unlock_hold_%0d", k), 32'(gnt), 32'b0100);
    end
    tick();
    check("unlock_rel", 32'(gnt), 32'd0);
    tick();
    check("unlock_next", 32'(gnt), 32'b1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_owner_arbiter.md
Name: bus_owner_arbiter

Overview:
- Round-robin arbiter sharing one tristate bus among NREQ requesters, each driving the bus through its own `driver` instance.
- Produces one-hot grants that feed each driver's data_en.
- Guarantees at most one driver is enabled at any time.
- Inserts dead (all-Z) turnaround cycles between owners so no two drivers ever contend.

Parameters:
- NREQ, 4: number of requesters; legal range 2..16.
- MAX_HOLD, 8: maximum consecutive owned cycles while another requester is waiting; must be >=1.
- TURN_CYC, 1: dead cycles (all enables low) between different owners; must be >=1.
- OWNW, $clog2(NREQ): width of the owner index (localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; level-sensitive; held while the requester wants the bus.
- gnt  output  NREQ  registered one-hot-or-zero grant; bit i drives data_en of driver i.
- owner  output  OWNW  index of the current owner; 0 when gnt==0.
- bus_idle  output  1  high when gnt==0 and the arbiter is not in the turnaround state.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it dominates every other input.
- Reset values: gnt=0, owner=0, bus_idle=1, state=IDLE, hold_cnt=0, turn_cnt=0, last=NREQ-1 (so requester 0 wins first after reset).
- All outputs are registered. No combinational path from req to gnt.
- States:
  - IDLE: gnt=0. If any req bit is set, pick the winner by round robin, searching from last+1 upward with wrap. Next edge: gnt=onehot(winner), owner=winner, last=winner, hold_cnt=0, state=OWN. If req==0, stay in IDLE.
  - OWN: hold_cnt increments each cycle and saturates at MAX_HOLD-1.
    - Release when req[owner]==0, or when hold_cnt==MAX_HOLD-1 and any other req bit is set.
    - On release, next edge: gnt=0, owner=0, turn_cnt=0, state=TURN.
    - With no competitor, the owner keeps the bus indefinitely. No dead cycle is inserted and gnt does not glitch.
  - TURN: gnt=0, bus_idle=0, turn_cnt increments. In the cycle where turn_cnt==TURN_CYC-1, perform the same arbitration as IDLE.
    - Winner exists: go to OWN with the new gnt on the next edge.
    - No winner: go to IDLE.
    - The previous owner may win again only if no other requester is set, per round-robin order.
- Latency:
  - Grant appears 1 cycle after req is first sampled in IDLE.
  - Release appears 1 cycle after the release condition.
  - Exactly TURN_CYC zero-gnt cycles separate any two grants.
- Boundary conditions:
  - A requester dropping req in the same cycle it is being arbitrated is not granted; only bits sampled high at the arbitration edge are eligible.
  - Wrap-around: the search from last+1 rolls from NREQ-1 back to 0.
  - Fairness: worst-case wait is (NREQ-1)*(MAX_HOLD+TURN_CYC)+TURN_CYC cycles.
  - rst in any state: outputs return to reset values on that edge. The in-progress ownership is abandoned with no turnaround.
- Invariant: $onehot0(gnt) on every cycle.

Optional Feature:
- Macro: BUS_OWNER_ARBITER_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While in OWN with req[owner]==1 and lock==1, the MAX_HOLD preemption is suppressed and hold_cnt is held at 0.
  - Release occurs only when req[owner] drops or lock deasserts and the hold limit is then reached.
  - lock is ignored in IDLE and TURN.
- Undefined: no lock port; behaviour as above.

Decomposition:
- Package bus_arb_pkg:
  - State encoding: IDLE=2'd0, OWN=2'd1, TURN=2'd2.
  - Common width function (clog2) and default constants.
- One sub-module, rr_pick (combinational):
  - Inputs: req[NREQ], last[OWNW].
  - Outputs: valid and idx[OWNW], implementing the round-robin search with wrap.

Test Plan:
1. rst=1 for 2 cycles with req=4'b1111 -> gnt=0, owner=0, bus_idle=1. After rst drops, gnt=4'b0001 on the next edge.
2. req=4'b0100 at cycle 0 -> gnt=4'b0100 and owner=2 at cycle 1. Drop req at cycle 3 -> gnt=0 at cycle 4 (TURN), bus_idle=1 at cycle 5.
3. MAX_HOLD=4, TURN_CYC=1, req=4'b1111 held -> owners 0,1,2,3,0 each for 4 cycles with one zero cycle between (grant period 5).
4. req=4'b0001 held for 20 cycles -> gnt=4'b0001 continuously with no dead cycle. Raise req[3] -> release after hold limit, 1 dead cycle, then gnt=4'b1000.
5. Owner 1 granted, rst pulsed 1 cycle -> gnt=0 on that edge. With req=4'b1010 afterwards -> first grant goes to requester 1 (last reset to 3).
6. 2000 cycles of random req -> $onehot0(gnt) always holds, at least TURN_CYC zero cycles between differing owners, and no requester waits beyond the fairness bound. With LOCK_EN and lock=1, owner 2 holds beyond MAX_HOLD despite req=4'b1111.
